// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t    - serial frame FSM states
//   PAR_*           - encodings of the PARITY parameter
//   clks_per_bit()  - system clocks per serial bit (integer truncation)
//   parity_bit()    - parity bit for a data byte under a given PARITY mode
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Odd mode makes the total count of ones (data + parity) odd, even mode even.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    if (mode == PAR_ODD) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter producing a clock-enable tick.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clear    in   restart the bit period (count returns to 0 on this edge)
//   tick     out  high in the last cycle of each bit period (count == N-1)
//   pre_tick out  high in the cycle before tick (count == N-2)
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  // Bit-period counter: 0..N-1, wrapping, restarted by clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick     = (count == LAST);
  assign pre_tick = (count == PRE);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, LSB first, start + 8 data + optional
// parity + 1 or 2 stop bits. Bit timing from uart_baud_gen clock enable.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   tx_valid  in   tx_data holds a byte to send
//   tx_data   in   byte to transmit, sampled on accept
//   tx_ready  out  block can accept a byte this cycle (registered)
//   tx        out  serial line, idle high (registered)
//   busy      out  frame in progress (registered)
//   done      out  one-cycle pulse in the last stop-bit cycle (registered)
module uart_tx #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t state;
  logic [7:0]  shift;
  logic [2:0]  idx;
  logic        stop_cnt;
  logic        par_bit;
  logic        tick;
  logic        pre_tick;
  logic        accept;

  assign accept = tx_valid && tx_ready && (state == IDLE);

  // Accepting a byte restarts the bit period so the frame is phase-aligned
  // to the accept edge.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Frame FSM with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= 8'h00;
      idx      <= 3'd0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            shift    <= tx_data;
            par_bit  <= parity_bit(tx_data, PARITY);
            idx      <= 3'd0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
          end else begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                state <= uart_pkg::PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              idx   <= idx + 3'd1;
              shift <= {1'b0, shift[7:1]};
              tx    <= shift[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          // The final stop cycle is spent in IDLE so a new byte can be
          // accepted there without leaving an idle gap on the line.
          if ((stop_cnt == LAST_STOP) && pre_tick) begin
            state    <= IDLE;
            done     <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            tx       <= 1'b1;
          end else if (tick) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the UART subsystem: accepts one byte per valid/ready handshake and shifts it out LSB-first as a start bit, 8 data bits, an optional parity bit and 1 or 2 stop bits on the `tx` line. The serial format matches the UART receiver. The block runs entirely in the `clk` domain. Bit timing comes from a clock-enable tick, not a derived clock.

## Interface
- `CLK_FREQ`, default 1000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `tx_valid`  input  1  `tx_data` holds a byte to send.
- `tx_data`  input  8  byte to transmit; sampled only on accept.
- `tx_ready`  output  1  block can accept a byte this cycle.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse when a frame completes.

## Operation
- `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, using integer truncation. Defaults give 104.
- Elaboration fails unless `CLKS_PER_BIT` ≥ 2, `PARITY` ∈ {0,1,2} and `STOP_BITS` ∈ {1,2}.
- Frame length `F = 1 + 8 + (PARITY != 0) + STOP_BITS` bits.
- **Accept rule:** a byte is accepted on a rising edge where `tx_valid && tx_ready`.
  - `tx_data` is latched into a shift register on that edge.
  - Parity is computed from the latched byte. Odd: the bit makes the total count of ones odd. Even: it makes the count even.
- **FSM states:** IDLE → START → DATA → PARITY (skipped when `PARITY == 0`) → STOP → IDLE.
  - Each state advances on the baud tick that ends its bit period.
  - DATA holds for 8 bit periods using a 3-bit index, LSB first.
  - STOP holds for `STOP_BITS` periods.
- **Output per state:** `tx` = 1 in IDLE, 0 in START, `shift[0]` in DATA, the parity bit in PARITY, 1 in STOP.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. It is cleared on accept, so every frame is phase-aligned to its accept edge. The tick fires when the count equals `CLKS_PER_BIT`-1.
- **`tx_ready`:** equals (state == IDLE) and not in reset.
- **`tx_valid` while busy:** ignored. `tx_ready` is 0, no data is latched, and the frame in flight is unaffected.

## Timing
- Let the accept edge be edge k.
- Start bit: `tx` = 0 in cycles k+1 … k+N, where N = `CLKS_PER_BIT`.
- Data bit i: driven in cycles k+1+(i+1)N … k+(i+2)N.
- Every bit lasts exactly N cycles.
- **End of frame:** the last STOP cycle is cycle k+F·N.
  - In that cycle the state is IDLE, `done` = 1 for exactly that cycle, `busy` = 0, `tx_ready` = 1, and `tx` = 1.
- **Back-to-back frames:** if `tx_valid` is high in the `done` cycle, the next byte is accepted there. Its start bit begins the following cycle, with no extra idle gap.
- **Reset values**, registered at the first edge with `rst` = 1:
  - `tx` = 1, `busy` = 0, `done` = 0, `tx_ready` = 0 while `rst` is held.
  - State IDLE, baud counter 0, bit index 0, shift register 0.
- **Reset mid-frame:** the frame is aborted and `tx` returns high on the next edge. No `done` is generated. `tx_ready` = 1 in the first cycle after `rst` deasserts.
- **`rst` together with `tx_valid`:** reset wins and nothing is accepted.

## Structure
- **Shared package `uart_pkg`:**
  - `uart_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Parity encodings: `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
  - Function `clks_per_bit(clk_freq, baud_rate)`.
- **Sub-module `uart_baud_gen`:** parameter `CLKS_PER_BIT`; inputs `clk`, `rst`, `clear`; output `tick`. The receiver migrates to the same generator later.
- **`uart_tx`:** FSM, shift register, parity bit, bit index and stop counter.

## Test plan
All scenarios use `CLK_FREQ` = 1000000 and `BAUD_RATE` = 100000, so N = 10.
- **8N1, byte 0xA5:** `tx` over 100 cycles reads 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. `done` pulses once at cycle k+100. `busy` is high for cycles k+1…k+99.
- **Parity, byte 0x07:** with `PARITY` = 2 the parity bit is 1; with `PARITY` = 1 it is 0. The frame is 110 cycles, and 120 cycles with `STOP_BITS` = 2.
- **Back-to-back 0x55 then 0xAA:** `tx_valid` is held high. The second start bit begins the cycle after the first `done`. No gap appears and both frames are bit-exact.
- **Valid while busy:** `tx_data` changes to 0x3C with `tx_valid` = 1 mid-frame. `tx_ready` stays 0 and the in-flight 0xA5 is unchanged.
- **Reset mid-frame:** `rst` is pulsed in data bit 3. `tx` = 1 the next cycle, with no `done`. After `rst` falls, `tx_ready` = 1 and a fresh 0x81 transmits correctly.
- **Idle line after reset:** with no `tx_valid` for 500 cycles, `tx` stays 1, `done` stays 0 and `tx_ready` stays 1.
